// File: rtl/tdp_ram_pkg.sv
// Shared constants, FSM state type and byte-enable merge helper for the
// parametrised true dual-port RAM.
package tdp_ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tdp_ram_port_pipe.sv
// Per-port read return path: optional output register stage for rvalid/data.
// Data only loads on a valid beat so dout holds between returns.
module tdp_ram_port_pipe #(
  parameter int DATA_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) data_q <= data_i;
    end
  end

  assign vld_o  = (OUT_REG != 0) ? vld_q  : vld_i;
  assign data_o = (OUT_REG != 0) ? data_q : data_i;

endmodule

// File: rtl/tdp_ram_param.sv
// Single-clock true dual-port RAM with byte enables, A-priority collision
// resolution, selectable read-during-write and a post-reset clear sweep.
//
// state   | meaning
// S_CLEAR | sweeping zeros into every word; requests dropped, init_busy high
// S_READY | normal two-port operation until the next reset
module tdp_ram_param
  import tdp_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0,
  parameter int CLEAR_EN = 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  output logic                init_busy_o,
  input  logic                a_en_i,
  input  logic                a_we_i,
  input  logic [DATA_W/8-1:0] a_be_i,
  input  logic [ADDR_W-1:0]   a_addr_i,
  input  logic [DATA_W-1:0]   a_din_i,
  output logic [DATA_W-1:0]   a_dout_o,
  output logic                a_rvalid_o,
  input  logic                b_en_i,
  input  logic                b_we_i,
  input  logic [DATA_W/8-1:0] b_be_i,
  input  logic [ADDR_W-1:0]   b_addr_i,
  input  logic [DATA_W-1:0]   b_din_i,
  output logic [DATA_W-1:0]   b_dout_o,
  output logic                b_rvalid_o,
  output logic                collision_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);
  localparam state_t            RST_STATE = (CLEAR_EN != 0) ? S_CLEAR : S_READY;

  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("tdp_ram_param: DATA_W must be a multiple of 8 between 8 and %0d", MAX_DATA_W);
  end

  function automatic logic [DATA_W-1:0] merge_w(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    return DATA_W'(be_merge(MAX_DATA_W'(old_w), MAX_DATA_W'(new_w), MAX_BE_W'(be)));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              coll_q, coll_d;
  logic              a_vld_q, b_vld_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  logic              ready, same_addr;
  logic              a_acc, b_acc, a_wr, b_wr;
  logic [DATA_W-1:0] a_new, b_new, a_rdata_d, b_rdata_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == CLR_LAST) state_d = S_READY;
    end
  end

  // Each port's "new" word applies B's bytes first, then A's, so A wins any
  // overlapping byte and both ports agree on the final word at a shared address.
  always_comb begin
    ready     = (state_q == S_READY);
    same_addr = (a_addr_i == b_addr_i);
    a_acc     = ready & a_en_i;
    b_acc     = ready & b_en_i;
    a_wr      = a_acc & a_we_i;
    b_wr      = b_acc & b_we_i;
    a_new = merge_w(merge_w(mem[a_addr_i], b_din_i, (b_wr && same_addr) ? b_be_i : '0),
                    a_din_i, a_wr ? a_be_i : '0);
    b_new = merge_w(merge_w(mem[b_addr_i], b_din_i, b_wr ? b_be_i : '0),
                    a_din_i, (a_wr && same_addr) ? a_be_i : '0);
    a_rdata_d = (RDW_MODE == RDW_WRITE_FIRST) ? a_new : mem[a_addr_i];
    b_rdata_d = (RDW_MODE == RDW_WRITE_FIRST) ? b_new : mem[b_addr_i];
    coll_d    = a_acc & b_acc & same_addr & (a_we_i | b_we_i);
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (a_wr) mem[a_addr_i] <= a_new;
      if (b_wr) mem[b_addr_i] <= b_new;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      coll_q    <= 1'b0;
      a_vld_q   <= 1'b0;
      b_vld_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      coll_q    <= coll_d;
      a_vld_q   <= a_acc;
      b_vld_q   <= b_acc;
      if (a_acc) a_rdata_q <= a_rdata_d;
      if (b_acc) b_rdata_q <= b_rdata_d;
    end
  end

  tdp_ram_port_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_a (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .vld_i   (a_vld_q),
    .data_i  (a_rdata_q),
    .vld_o   (a_rvalid_o),
    .data_o  (a_dout_o)
  );

  tdp_ram_port_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_b (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .vld_i   (b_vld_q),
    .data_i  (b_rdata_q),
    .vld_o   (b_rvalid_o),
    .data_o  (b_dout_o)
  );

  assign init_busy_o = (state_q == S_CLEAR);
  assign collision_o = coll_q;

endmodule

// File: tb/tb_tdp_ram_param.sv
// Scoreboard bench for tdp_ram_param: 16-bit words, 8 entries, write-first,
// output register enabled, clear sweep enabled.
module tb_tdp_ram_param;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int RDW_MODE = 1;
  localparam int OUT_REG  = 1;
  localparam int CLEAR_EN = 1;
  localparam int LAT      = 1 + OUT_REG;
  localparam bit WF       = (RDW_MODE == 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_busy;
  logic              a_en, a_we, b_en, b_we;
  logic [1:0]        a_be, b_be;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_din, b_din, a_dout, b_dout;
  logic              a_rvalid, b_rvalid, collision;

  always #5 clk = ~clk;

  tdp_ram_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(RDW_MODE),
    .OUT_REG(OUT_REG), .CLEAR_EN(CLEAR_EN)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .init_busy_o(init_busy),
    .a_en_i(a_en), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr),
    .a_din_i(a_din), .a_dout_o(a_dout), .a_rvalid_o(a_rvalid),
    .b_en_i(b_en), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr),
    .b_din_i(b_din), .b_dout_o(b_dout), .b_rvalid_o(b_rvalid),
    .collision_o(collision)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   qc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever a port presents data.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (a_rvalid) begin
        if (qa.size() == 0) chk("a_rvalid_unexpected", 32'(a_rvalid), 32'd0);
        else begin
          e = qa.pop_front();
          chk("a_dout", 32'(a_dout), 32'(e.data));
          chk("a_latency", 32'(cyc), 32'(e.due));
        end
      end
      if (b_rvalid) begin
        if (qb.size() == 0) chk("b_rvalid_unexpected", 32'(b_rvalid), 32'd0);
        else begin
          e = qb.pop_front();
          chk("b_dout", 32'(b_dout), 32'(e.data));
          chk("b_latency", 32'(cyc), 32'(e.due));
        end
      end
      if (qc.size() != 0 && qc[0] == cyc) begin
        void'(qc.pop_front());
        chk("collision", 32'(collision), 32'd1);
      end else if (collision) begin
        chk("collision_unexpected", 32'(collision), 32'd0);
      end
    end
  end

  task automatic op_a(input logic we, input logic [1:0] be, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] din, input logic [DATA_W-1:0] exp);
    a_en = 1'b1; a_we = we; a_be = be; a_addr = addr; a_din = din;
    qa.push_back('{data: exp, due: cyc + LAT});
  endtask

  task automatic op_b(input logic we, input logic [1:0] be, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] din, input logic [DATA_W-1:0] exp);
    b_en = 1'b1; b_we = we; b_be = be; b_addr = addr; b_din = din;
    qb.push_back('{data: exp, due: cyc + LAT});
  endtask

  task automatic tick();
    @(negedge clk);
    a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; b_we = 1'b0;
  endtask

  task automatic count_busy(output int n, output logic seen_rv);
    n = 0;
    seen_rv = 1'b0;
    while (init_busy && n < 100) begin
      n++;
      if (a_rvalid || b_rvalid) seen_rv = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    logic seen;
    rst_n = 1'b0;
    a_en = 0; a_we = 0; a_be = 0; a_addr = 0; a_din = 0;
    b_en = 0; b_we = 0; b_be = 0; b_addr = 0; b_din = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a_dout", 32'(a_dout), 32'd0);
    chk("rst_b_dout", 32'(b_dout), 32'd0);
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("rst_collision", 32'(collision), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);

    // Clear sweep with requests held active that must all be dropped.
    @(negedge clk);
    rst_n = 1'b1;
    a_en = 1'b1; a_we = 1'b1; a_be = 2'b11; a_addr = 3'd2; a_din = 16'hFFFF;
    b_en = 1'b1; b_addr = 3'd5;
    count_busy(n, seen);
    a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
    chk("clear_busy_cycles", 32'(n), 32'd8);
    chk("clear_no_rvalid", 32'(seen), 32'd0);

    for (int i = 0; i < 8; i++) begin
      op_a(1'b0, 2'b00, 3'(i), 16'h0, 16'h0000);
      op_b(1'b0, 2'b00, 3'(7 - i), 16'h0, 16'h0000);
      tick();
    end

    op_a(1'b1, 2'b01, 3'd2, 16'h00A5, WF ? 16'h00A5 : 16'h0000); tick();
    op_b(1'b0, 2'b00, 3'd2, 16'h0,    16'h00A5);                 tick();

    op_a(1'b1, 2'b11, 3'd4, 16'h1234, WF ? 16'h1234 : 16'h0000); tick();
    op_a(1'b1, 2'b10, 3'd4, 16'hABCD, WF ? 16'hAB34 : 16'h1234); tick();
    op_a(1'b0, 2'b00, 3'd4, 16'h0,    16'hAB34);                 tick();

    op_a(1'b1, 2'b11, 3'd5, 16'h0011, WF ? 16'h0011 : 16'h0000); tick();
    op_a(1'b1, 2'b11, 3'd5, 16'h0022, WF ? 16'h0022 : 16'h0011);
    op_b(1'b0, 2'b00, 3'd5, 16'h0,    WF ? 16'h0022 : 16'h0011);
    qc.push_back(cyc + 1); tick();
    op_b(1'b1, 2'b11, 3'd5, 16'h0033, WF ? 16'h0033 : 16'h0022);
    op_a(1'b0, 2'b00, 3'd5, 16'h0,    WF ? 16'h0033 : 16'h0022);
    qc.push_back(cyc + 1); tick();

    op_a(1'b1, 2'b01, 3'd3, 16'h00AA, WF ? 16'h00AA : 16'h0000);
    op_b(1'b1, 2'b01, 3'd3, 16'h0055, WF ? 16'h00AA : 16'h0000);
    qc.push_back(cyc + 1); tick();
    op_a(1'b0, 2'b00, 3'd3, 16'h0,    16'h00AA); tick();

    op_a(1'b1, 2'b01, 3'd6, 16'h1111, WF ? 16'h2211 : 16'h0000);
    op_b(1'b1, 2'b10, 3'd6, 16'h2222, WF ? 16'h2211 : 16'h0000);
    qc.push_back(cyc + 1); tick();
    op_a(1'b1, 2'b11, 3'd7, 16'hAAAA, WF ? 16'hAAAA : 16'h0000);
    op_b(1'b1, 2'b11, 3'd7, 16'hBBBB, WF ? 16'hAAAA : 16'h0000);
    qc.push_back(cyc + 1); tick();

    op_a(1'b0, 2'b00, 3'd6, 16'h0,    16'h2211);
    op_b(1'b0, 2'b00, 3'd6, 16'h0,    16'h2211); tick();
    op_a(1'b1, 2'b00, 3'd6, 16'hFFFF, 16'h2211); tick();
    op_a(1'b0, 2'b00, 3'd7, 16'h0,    16'hAAAA);
    op_b(1'b0, 2'b00, 3'd6, 16'h0,    16'h2211); tick();

    op_b(1'b1, 2'b11, 3'd1, 16'hCAFE, WF ? 16'hCAFE : 16'h0000); tick();
    op_a(1'b0, 2'b00, 3'd1, 16'h0,    16'hCAFE);                 tick();
    drain();

    repeat (3) @(negedge clk);
    chk("a_dout_hold", 32'(a_dout), 32'hCAFE);
    chk("b_dout_hold", 32'(b_dout), WF ? 32'hCAFE : 32'h0000);
    chk("idle_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);

    // Async reset mid-cycle, then another one part-way through the sweep.
    #2 rst_n = 1'b0;
    #1;
    chk("areset_a_dout", 32'(a_dout), 32'd0);
    chk("areset_b_dout", 32'(b_dout), 32'd0);
    chk("areset_busy", 32'(init_busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midclear_busy", 32'(init_busy), 32'd1);
    chk("midclear_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n, seen);
    chk("restart_busy_cycles", 32'(n), 32'd8);

    op_a(1'b0, 2'b00, 3'd2, 16'h0, 16'h0000);
    op_b(1'b0, 2'b00, 3'd1, 16'h0, 16'h0000); tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
